// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset/lock sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    localparam int DEF_N_DOMAINS      = 6;
    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_STABLE    = 1024;
    localparam int DEF_LOCK_TIMEOUT   = 65536;
    localparam int DEF_DOMAIN_GAP     = 8;
    localparam int DEF_LOSS_FILTER    = 4;
    localparam int DEF_CNT_W          = 17;

    localparam int RETRY_W = 8;
    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

    // Saturating increment for the retry counter.
    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
        return (v == RETRY_MAX) ? v : v + RETRY_W'(1);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs, cleared by async reset.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset/lock sequencer: pulses pll_rst, qualifies lock, releases domain resets in order.
// Latency: locked seen 2 cycles late through sync2; all outputs straight from flops.
// Backpressure: none; sw_reset/clr_status are single-cycle pulses sampled every cycle.
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int N_DOMAINS      = DEF_N_DOMAINS,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE    = DEF_LOCK_STABLE,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int DOMAIN_GAP     = DEF_DOMAIN_GAP,
    parameter int LOSS_FILTER    = DEF_LOSS_FILTER,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                 clkin,
    input  logic                 rst_n,
    input  logic                 locked,
    input  logic                 sw_reset,
    input  logic                 clr_status,
    output logic                 pll_rst,
    output logic [N_DOMAINS-1:0] dom_rst_n,
    output logic                 ready,
    output logic [2:0]           state,
    output logic [RETRY_W-1:0]   retry_cnt,
    output logic                 lock_lost
);

    localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DOMAIN_GAP - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_FILTER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_DOMAINS - 1);

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             lk_s;
    logic             timeout_evt;
    logic             loss_evt;
    logic             bump;

    sync2 #(.W(1)) u_lock_sync (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     (locked),
        .q     (lk_s)
    );

    assign state = st;

    // In RELEASE any unlocked cycle is a loss; in RUN it must persist LOSS_FILTER cycles.
    assign timeout_evt = (st == ST_WAIT_LOCK) && !lk_s && (cnt == TO_LAST);
    assign loss_evt    = !lk_s && ((st == ST_RELEASE) ||
                                   ((st == ST_RUN) && (cnt == LOSS_LAST)));
    assign bump        = !sw_reset && (timeout_evt || loss_evt);

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_PLL_RST;
            cnt       <= '0;
            idx       <= '0;
            pll_rst   <= 1'b1;
            dom_rst_n <= '0;
            ready     <= 1'b0;
        end else if (sw_reset || loss_evt) begin
            // All domains drop together; only the release is sequenced.
            st        <= ST_PLL_RST;
            cnt       <= '0;
            idx       <= '0;
            pll_rst   <= 1'b1;
            dom_rst_n <= '0;
            ready     <= 1'b0;
        end else begin
            case (st)
                ST_PLL_RST: begin
                    if (cnt == PLL_LAST) begin
                        st      <= ST_WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lk_s) begin
                        st  <= ST_STABLE;
                        cnt <= '0;
                    end else if (timeout_evt) begin
                        st      <= ST_PLL_RST;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!lk_s) begin
                        st  <= ST_WAIT_LOCK;
                        cnt <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        st  <= ST_RELEASE;
                        cnt <= '0;
                        idx <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        cnt       <= '0;
                        dom_rst_n <= dom_rst_n | (N_DOMAINS'(1) << idx);
                        if (idx == IDX_LAST) begin
                            st    <= ST_RUN;
                            ready <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    cnt <= lk_s ? '0 : cnt + CNT_W'(1);
                end
                default: begin
                    st        <= ST_PLL_RST;
                    cnt       <= '0;
                    idx       <= '0;
                    pll_rst   <= 1'b1;
                    dom_rst_n <= '0;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

    // A same-cycle event beats clr_status: clear first, then count/set.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= '0;
            lock_lost <= 1'b0;
        end else begin
            if (bump) begin
                retry_cnt <= clr_status ? RETRY_W'(1) : sat_inc(retry_cnt);
            end else if (clr_status) begin
                retry_cnt <= '0;
            end

            if (!sw_reset && loss_evt) begin
                lock_lost <= 1'b1;
            end else if (clr_status) begin
                lock_lost <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed-random bench for pll_reset_seq against a timeline model of the sequence.
// Expected values come from cycle arithmetic on the small test parameters.
module tb_pll_reset_seq;

    localparam int P_N   = 6;
    localparam int P_PRC = 4;
    localparam int P_STB = 8;
    localparam int P_TO  = 32;
    localparam int P_GAP = 2;
    localparam int P_LF  = 3;

    typedef struct {
        logic       pll_rst;
        logic [5:0] dom;
        logic       ready;
        logic [2:0] st;
    } exp_t;

    logic           clkin = 1'b0;
    logic           rst_n = 1'b1;
    logic           locked = 1'b0;
    logic           sw_reset = 1'b0;
    logic           clr_status = 1'b0;
    logic           pll_rst;
    logic [P_N-1:0] dom_rst_n;
    logic           ready;
    logic [2:0]     state;
    logic [7:0]     retry_cnt;
    logic           lock_lost;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #10 clkin = ~clkin;

    pll_reset_seq #(
        .N_DOMAINS      (P_N),
        .PLL_RST_CYCLES (P_PRC),
        .LOCK_STABLE    (P_STB),
        .LOCK_TIMEOUT   (P_TO),
        .DOMAIN_GAP     (P_GAP),
        .LOSS_FILTER    (P_LF),
        .CNT_W          (17)
    ) dut (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .locked     (locked),
        .sw_reset   (sw_reset),
        .clr_status (clr_status),
        .pll_rst    (pll_rst),
        .dom_rst_n  (dom_rst_n),
        .ready      (ready),
        .state      (state),
        .retry_cnt  (retry_cnt),
        .lock_lost  (lock_lost)
    );

    // t = cycles since the sequence (re)started in PLL_RST; c1 = first WAIT_LOCK cycle with lk_s=1.
    function automatic exp_t model(input int t, input int c1);
        exp_t e;
        int   r;
        int   k;
        r = c1 + 1 + P_STB;
        k = (t < r) ? 0 : (t - r) / P_GAP;
        if (k > P_N) k = P_N;
        e.pll_rst = (t < P_PRC);
        e.dom     = 6'((1 << k) - 1);
        e.ready   = (t >= r + P_GAP * P_N);
        if (t < P_PRC)     e.st = 3'd0;
        else if (t <= c1)  e.st = 3'd1;
        else if (t < r)    e.st = 3'd2;
        else if (!e.ready) e.st = 3'd3;
        else               e.st = 3'd4;
        return e;
    endfunction

    function automatic int maxi(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic tick();
        @(posedge clkin);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_seq(input int base, input int c1, input int last,
                           input int er, input logic el);
        exp_t e;
        forever begin
            e = model(cyc - base, c1);
            chk("pll_rst",   32'(pll_rst),   32'(e.pll_rst));
            chk("dom_rst_n", 32'(dom_rst_n), 32'(e.dom));
            chk("ready",     32'(ready),     32'(e.ready));
            chk("state",     32'(state),     32'(e.st));
            chk("retry_cnt", 32'(retry_cnt), 32'(er));
            chk("lock_lost", 32'(lock_lost), 32'(el));
            if (cyc - base >= last) break;
            tick();
        end
    endtask

    // Asserts rst_n between edges and checks the outputs before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_state",     32'(state),     32'd0);
        chk("rst_pll_rst",   32'(pll_rst),   32'd1);
        chk("rst_dom",       32'(dom_rst_n), 32'd0);
        chk("rst_ready",     32'(ready),     32'd0);
        chk("rst_retry",     32'(retry_cnt), 32'd0);
        chk("rst_lock_lost", 32'(lock_lost), 32'd0);
        @(posedge clkin);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        int per;
        int lk_at;
        int c1;
        int len;
        int a;
        int b;
        int base2;
        int base3;
        int c1b;
        int tgt;

        per = P_PRC + P_TO;
        #5;

        // Lock timeout: pll_rst re-pulses every per cycles, retry_cnt counts up.
        locked = 1'b0;
        do_reset();
        while (cyc <= 3 * per + 4) begin
            chk("to_pll_rst", 32'(pll_rst),   32'((cyc % per) < P_PRC));
            chk("to_state",   32'(state),     32'(((cyc % per) < P_PRC) ? 0 : 1));
            chk("to_dom",     32'(dom_rst_n), 32'd0);
            chk("to_ready",   32'(ready),     32'd0);
            chk("to_retry",   32'(retry_cnt), 32'(cyc / per));
            tick();
        end

        // clr_status on the same edge as the 4th timeout: increment wins.
        while (cyc < 4 * per - 1) tick();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("clr_vs_timeout_retry", 32'(retry_cnt), 32'd1);
        chk("clr_vs_timeout_pll",   32'(pll_rst),   32'd1);

        tgt = 4 * per + P_PRC + 2 + $urandom_range(0, 20);
        while (cyc < tgt) tick();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("clr_alone_retry", 32'(retry_cnt), 32'd0);

        // Nominal bring-up with a random lock time.
        locked = 1'b0;
        do_reset();
        lk_at = $urandom_range(0, 25);
        while (cyc < lk_at) tick();
        locked = 1'b1;
        c1 = maxi(P_PRC, lk_at + 2);
        chk_seq(0, c1, c1 + 1 + P_STB + P_GAP * P_N + 2, 0, 1'b0);

        // Short unlock in RUN is filtered out.
        len = $urandom_range(1, P_LF - 1);
        tick();
        locked = 1'b0;
        a = cyc;
        while (cyc < a + 8) begin
            if (cyc == a + len) locked = 1'b1;
            chk_seq(0, c1, cyc, 0, 1'b0);
            tick();
        end

        // Unlock long enough to count as lock loss.
        len = $urandom_range(P_LF, P_LF + 2);
        locked = 1'b0;
        b = cyc;
        while (cyc < b + 2 + P_LF) begin
            if (cyc == b + len) locked = 1'b1;
            chk_seq(0, c1, cyc, 0, 1'b0);
            tick();
        end
        if (cyc == b + len) locked = 1'b1;
        base2 = cyc;
        c1b   = maxi(P_PRC, b + len + 2 - base2);
        chk_seq(base2, c1b, c1b + 1 + P_STB + 3 * P_GAP, 1, 1'b1);
        chk("dom_000111", 32'(dom_rst_n), 32'h07);

        // sw_reset mid-RELEASE, then a full sequence.
        sw_reset = 1'b1;
        tick();
        sw_reset = 1'b0;
        base3 = cyc;
        chk("sw_state", 32'(state),     32'd0);
        chk("sw_dom",   32'(dom_rst_n), 32'd0);
        chk("sw_retry", 32'(retry_cnt), 32'd1);
        chk_seq(base3, P_PRC, P_PRC + 1 + P_STB + P_GAP * P_N + 1, 1, 1'b1);

        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("clr_run_retry", 32'(retry_cnt), 32'd0);
        chk("clr_run_lost",  32'(lock_lost), 32'd0);

        // Async reset mid-RUN, then lock chatter in STABLE at count 5.
        locked = 1'b0;
        do_reset();
        lk_at = $urandom_range(2, 20);
        while (cyc < lk_at) tick();
        locked = 1'b1;
        c1 = lk_at + 2;
        chk_seq(0, c1, c1 + 4, 0, 1'b0);
        locked = 1'b0;
        tick();
        locked = 1'b1;
        chk_seq(0, c1, c1 + 6, 0, 1'b0);
        tick();
        chk("chatter_state", 32'(state), 32'd1);
        chk_seq(0, c1 + 7, c1 + 7 + 1 + P_STB + P_GAP * P_N + 1, 0, 1'b0);

        // Retry counter saturation over 260 timeouts.
        locked = 1'b0;
        do_reset();
        for (int k = 1; k <= 260; k++) begin
            while (cyc < k * per - 1) tick();
            chk("sat_before", 32'(retry_cnt), 32'(sat255(k - 1)));
            tick();
            chk("sat_after",  32'(retry_cnt), 32'(sat255(k)));
            chk("sat_pll",    32'(pll_rst),   32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
